fpu_mant_mul: RTL and testbench
===============================

Name: fpu_mant_mul

Overview:
- Parametrised sequential unsigned mantissa multiplier for the Sol-1 FPU; successor to the fixed-width radix-2 shift-add multiplier.
- Retires BITS_PER_CYCLE multiplier bits per iteration.
- Uses a start/valid/ack handshake compatible with the FPU main controller (idle→wait→finish→wait_ack).
- Instantiated by the arithmetic FSM for op_mul and op_square; exponent and sign handling stay outside.

Parameters:
MANT_W, 24, operand width in bits (≥2; 24 for single precision, 53 for double).
BITS_PER_CYCLE, 1, multiplier bits consumed per iteration (1, 2, 4 or 8; ≤ MANT_W).

Ports:
clk  in  1  clock, rising edge.
arst_n  in  1  asynchronous active-low reset.
start_i  in  1  request; sampled only in idle.
abort_i  in  1  synchronous abort, any state.
a_i  in  MANT_W  multiplicand; captured on an accepted start.
b_i  in  MANT_W  multiplier; captured on an accepted start.
ack_i  in  1  consumer acknowledge of the result.
busy_o  out  1  high in every state except idle.
valid_o  out  1  result valid; held until ack.
product_o  out  2*MANT_W  exact product a×b; stable while valid_o is high.
zero_o  out  1  product == 0; qualified by valid_o.

Behaviour:
- Definitions:
  - N = ceil(MANT_W / BITS_PER_CYCLE).
  - The multiplier is zero-extended to N×BITS_PER_CYCLE bits and processed MSB-chunk first.
  - Iteration step: P ← (P << BITS_PER_CYCLE) + a × chunk.
  - Accumulator is 2*MANT_W+BITS_PER_CYCLE bits; it never overflows, and the top BITS_PER_CYCLE bits are provably 0 at the end.
- Reset: state idle; busy_o, valid_o, zero_o = 0; product_o = 0; iteration counter = 0.
- FSM states (mmul_*):
  - idle: start_i=1 → latch a_i/b_i, clear P, counter = N → start.
  - start: one cycle → iter.
  - iter: one step per cycle, counter decrements; when counter reaches 1 after the step → result_set.
  - result_set: product_o and zero_o registered from P → result_valid.
  - result_valid: valid_o=1. ack_i=1 → idle next cycle, valid_o drops that edge.
- Latency: start accepted at edge k gives valid_o high from edge k+N+2. Example: MANT_W=24, BPC=1 → 26; BPC=4 → 8.
- Throughput: ack_i and start_i together in result_valid → ack honoured, return to idle. The new start is NOT accepted in that cycle; back-to-back issue costs one idle cycle.
- Output stability:
  - start_i outside idle is ignored; operands are not re-latched.
  - ack_i outside result_valid is ignored.
  - product_o and zero_o hold their last value after ack until the next result_set.
- abort_i:
  - Highest priority; in any state the next state is idle and valid_o=0.
  - product_o is not updated.
  - abort_i and start_i both high in idle → abort wins, no capture.
- Reset mid-operation: asynchronous return to reset values; no partial result is ever flagged valid.
- Operands of 0 or all-ones need no special casing: 0xFFFFFF×0xFFFFFF = 0xFFFFFE000001.

Optional Feature:
FPU_MUL_EARLY_EXIT_EN
- Defined:
  - On capture, and after every iteration, if all remaining unprocessed multiplier chunks are zero, go directly to result_set.
  - result_set applies P << (remaining_chunks × BITS_PER_CYCLE) with a barrel shift.
  - b_i=0 gives valid_o at edge k+2.
  - Latency = (index of lowest nonzero chunk counted from MSB chunk, 1-based) + 2.
- Undefined: fixed latency N+2 for all operands; no barrel shifter is instantiated.
- The product value is identical in both builds.

Decomposition:
- Package pa_fpu gains:
  - typedef enum e_mmul_states {mmul_idle_st, mmul_start_st, mmul_iter_st, mmul_result_set_st, mmul_result_valid_st}, 3 bits.
  - Localparam defaults MANT_W_SP=24 and MANT_W_DP=53 for instantiation.
- One sub-module, fpu_mant_mul_step: combinational P_next = (P << BPC) + a × chunk, parametrised on MANT_W and BITS_PER_CYCLE, so it can be reused by a future pipelined multiplier.
- Counter, FSM and handshake stay in the top module.

Test Plan:
- MANT_W=24, BPC=1, a=b=0xFFFFFF, start at edge k:
  - valid_o rises at edge k+26, product_o=0x0000FFFFFE000001, zero_o=0.
  - Hold ack_i=0 for 5 cycles → outputs stable. ack_i=1 → valid_o=0 next edge, busy_o=0.
- MANT_W=24, BPC=4: a=0x800000, b=0xC00000 → product 0x600000000000, valid at k+8.
- Sweep BPC∈{1,2,4,8}, MANT_W∈{24,53} with 1000 random operands each:
  - product matches the reference model.
  - Latency equals N+2 (early exit off) or the computed value (on).
- b=0: zero_o=1, product 0; with FPU_MUL_EARLY_EXIT_EN, valid at k+2.
- Protocol edges:
  - start_i pulsed during iter with different operands → result unchanged.
  - abort_i at iteration 3 → idle next cycle, valid_o never rises, product_o keeps the previous result.
- arst_n low during iter → all outputs 0 immediately. After release, a new start completes correctly.

Source files
------------

// File: rtl/fpu_mant_mul_pkg.sv
// rtl/fpu_mant_mul_pkg.sv - shared types and constants for the Sol-1 FPU mantissa multiplier (package pa_fpu)
package pa_fpu;

    // Operand widths used when instantiating the multiplier.
    localparam int MANT_W_SP = 24;
    localparam int MANT_W_DP = 53;

    // Multiplier control states.
    typedef enum logic [2:0] {
        mmul_idle_st         = 3'd0,
        mmul_start_st        = 3'd1,
        mmul_iter_st         = 3'd2,
        mmul_result_set_st   = 3'd3,
        mmul_result_valid_st = 3'd4
    } e_mmul_states;

    // Number of multiplier chunks of bpc bits needed to cover mant_w bits.
    function automatic int mmul_num_chunks(input int mant_w, input int bpc);
        return (mant_w + bpc - 1) / bpc;
    endfunction

endpackage

// File: rtl/fpu_mant_mul_step.sv
// rtl/fpu_mant_mul_step.sv - one radix-2^BITS_PER_CYCLE shift-add step: P_next = (P << BPC) + a * chunk
module fpu_mant_mul_step #(
    parameter int MANT_W         = 24,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [2*MANT_W-1:0]                i_p,
    input  logic [MANT_W-1:0]                  i_a,
    input  logic [BITS_PER_CYCLE-1:0]          i_chunk,
    output logic [2*MANT_W+BITS_PER_CYCLE-1:0] o_p
);

    localparam int ACC_W = 2*MANT_W + BITS_PER_CYCLE;

    // Before any step the running product is below 2^(2*MANT_W), so only the
    // low 2*MANT_W accumulator bits need to enter the step.
    logic [ACC_W-1:0] w_shifted;
    logic [ACC_W-1:0] w_partial;

    assign w_shifted = ACC_W'(i_p) << BITS_PER_CYCLE;
    assign w_partial = ACC_W'(i_a) * ACC_W'(i_chunk);
    assign o_p       = w_shifted + w_partial;

endmodule

// File: rtl/fpu_mant_mul.sv
// rtl/fpu_mant_mul.sv - sequential unsigned mantissa multiplier; optional early exit via FPU_MUL_EARLY_EXIT_EN
module fpu_mant_mul
    import pa_fpu::*;
#(
    parameter int MANT_W         = MANT_W_SP,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [MANT_W-1:0]     a_i,
    input  logic [MANT_W-1:0]     b_i,
    input  logic                  ack_i,
    output logic                  busy_o,
    output logic                  valid_o,
    output logic [2*MANT_W-1:0]   product_o,
    output logic                  zero_o
);

    localparam int BPC   = BITS_PER_CYCLE;
    localparam int N     = mmul_num_chunks(MANT_W, BPC);
    localparam int NB    = N * BPC;
    localparam int ACC_W = 2*MANT_W + BPC;
    localparam int CNT_W = $clog2(N + 1);

    e_mmul_states        r_state;
    e_mmul_states        w_next_state;
    logic [MANT_W-1:0]   r_a;
    logic [NB-1:0]       r_b;
    logic [ACC_W-1:0]    r_p;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*MANT_W-1:0] r_product;
    logic                r_zero;

    logic [BPC-1:0]      w_chunk;
    logic [NB-1:0]       w_b_shifted;
    logic [ACC_W-1:0]    w_p_next;
    logic [ACC_W-1:0]    w_final;

    // The multiplier register keeps unprocessed chunks left-aligned, so the
    // next chunk is always the top BPC bits and "rest is zero" is a plain compare.
    assign w_chunk     = r_b[NB-1 -: BPC];
    assign w_b_shifted = r_b << BPC;

    fpu_mant_mul_step #(
        .MANT_W         (MANT_W),
        .BITS_PER_CYCLE (BPC)
    ) u_step (
        .i_p     (r_p[2*MANT_W-1:0]),
        .i_a     (r_a),
        .i_chunk (w_chunk),
        .o_p     (w_p_next)
    );

`ifdef FPU_MUL_EARLY_EXIT_EN
    localparam int SH_W = $clog2(NB + 1);
    logic [SH_W-1:0] w_shamt;

    // Chunks skipped by an early exit are all zero, so the final product is the
    // partial product scaled by the skipped chunk positions.
    assign w_shamt = SH_W'(r_cnt) * SH_W'(BPC);
    assign w_final = r_p << w_shamt;
`else
    assign w_final = r_p;
`endif

    // State register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= mmul_idle_st;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; abort overrides everything and returns to idle.
    always_comb begin
        w_next_state = r_state;
        if (abort_i) begin
            w_next_state = mmul_idle_st;
        end else begin
            case (r_state)
                mmul_idle_st: begin
                    if (start_i) begin
                        w_next_state = mmul_start_st;
                    end
                end
                mmul_start_st: begin
`ifdef FPU_MUL_EARLY_EXIT_EN
                    if (r_b == '0) begin
                        w_next_state = mmul_result_set_st;
                    end else begin
                        w_next_state = mmul_iter_st;
                    end
`else
                    w_next_state = mmul_iter_st;
`endif
                end
                mmul_iter_st: begin
                    if (r_cnt == CNT_W'(1)) begin
                        w_next_state = mmul_result_set_st;
`ifdef FPU_MUL_EARLY_EXIT_EN
                    end else if (w_b_shifted == '0) begin
                        w_next_state = mmul_result_set_st;
`endif
                    end
                end
                mmul_result_set_st: begin
                    w_next_state = mmul_result_valid_st;
                end
                mmul_result_valid_st: begin
                    if (ack_i) begin
                        w_next_state = mmul_idle_st;
                    end
                end
                default: begin
                    w_next_state = mmul_idle_st;
                end
            endcase
        end
    end

    // Operand capture, accumulation and result registration; frozen on abort.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_p       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
            r_zero    <= 1'b0;
        end else if (!abort_i) begin
            case (r_state)
                mmul_idle_st: begin
                    if (start_i) begin
                        r_a   <= a_i;
                        r_b   <= NB'(b_i);
                        r_p   <= '0;
                        r_cnt <= CNT_W'(N);
                    end
                end
                mmul_iter_st: begin
                    r_p   <= w_p_next;
                    r_b   <= w_b_shifted;
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                mmul_result_set_st: begin
                    r_product <= w_final[2*MANT_W-1:0];
                    r_zero    <= (w_final == '0);
                end
                default: begin
                end
            endcase
        end
    end

    assign busy_o    = (r_state != mmul_idle_st);
    assign valid_o   = (r_state == mmul_result_valid_st);
    assign product_o = r_product;
    assign zero_o    = r_zero;

endmodule

// File: tb/tb_fpu_mant_mul.sv
// tb/tb_fpu_mant_mul.sv - self-checking bench for fpu_mant_mul (SP/BPC1, SP/BPC4, DP/BPC8 instances)
module tb_fpu_mant_mul;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        start;
    logic        abort;
    logic        ack;
    logic [52:0] a_in;
    logic [52:0] b_in;

    logic         busy0, valid0, zero0;
    logic         busy1, valid1, zero1;
    logic         busy2, valid2, zero2;
    logic [47:0]  prod0, prod1;
    logic [105:0] prod2;

    logic         vld [3];
    logic         bsy [3];
    logic         zro [3];
    logic [127:0] prd [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fpu_mant_mul #(.MANT_W(24), .BITS_PER_CYCLE(1)) u_dut_sp1 (
        .clk(clk), .arst_n(arst_n), .start_i(start), .abort_i(abort),
        .a_i(a_in[23:0]), .b_i(b_in[23:0]), .ack_i(ack),
        .busy_o(busy0), .valid_o(valid0), .product_o(prod0), .zero_o(zero0));

    fpu_mant_mul #(.MANT_W(24), .BITS_PER_CYCLE(4)) u_dut_sp4 (
        .clk(clk), .arst_n(arst_n), .start_i(start), .abort_i(abort),
        .a_i(a_in[23:0]), .b_i(b_in[23:0]), .ack_i(ack),
        .busy_o(busy1), .valid_o(valid1), .product_o(prod1), .zero_o(zero1));

    fpu_mant_mul #(.MANT_W(53), .BITS_PER_CYCLE(8)) u_dut_dp8 (
        .clk(clk), .arst_n(arst_n), .start_i(start), .abort_i(abort),
        .a_i(a_in), .b_i(b_in), .ack_i(ack),
        .busy_o(busy2), .valid_o(valid2), .product_o(prod2), .zero_o(zero2));

    assign vld[0] = valid0;  assign vld[1] = valid1;  assign vld[2] = valid2;
    assign bsy[0] = busy0;   assign bsy[1] = busy1;   assign bsy[2] = busy2;
    assign zro[0] = zero0;   assign zro[1] = zero1;   assign zro[2] = zero2;
    assign prd[0] = 128'(prod0);
    assign prd[1] = 128'(prod1);
    assign prd[2] = 128'(prod2);

    function automatic int cfg_w(input int i);
        return (i == 2) ? 53 : 24;
    endfunction

    function automatic int cfg_bpc(input int i);
        case (i)
            0:       return 1;
            1:       return 4;
            default: return 8;
        endcase
    endfunction

    function automatic logic [127:0] wmask(input int i);
        return (128'(1) << cfg_w(i)) - 128'(1);
    endfunction

    // Reference product: plain integer multiplication of the operand bits the instance sees.
    function automatic logic [127:0] ref_prod(input int i, input logic [52:0] a, input logic [52:0] b);
        return (128'(a) & wmask(i)) * (128'(b) & wmask(i));
    endfunction

    // Reference latency in edges after the accepting edge.
    function automatic int ref_lat(input int i, input logic [52:0] b);
        int n;
        n = (cfg_w(i) + cfg_bpc(i) - 1) / cfg_bpc(i);
`ifdef FPU_MUL_EARLY_EXIT_EN
        begin
            logic [127:0] bb;
            logic [127:0] cmask;
            bb    = 128'(b) & wmask(i);
            cmask = (128'(1) << cfg_bpc(i)) - 128'(1);
            if (bb == '0) return 2;
            for (int j = 0; j < n; j++) begin
                if (((bb >> (j * cfg_bpc(i))) & cmask) != '0) return (n - j) + 2;
            end
        end
`else
        if (b === 'x) return -2;
`endif
        return n + 2;
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // One complete transaction on all three instances; optional start pulse
    // during the run and optional start asserted together with ack.
    task automatic run_op(input logic [52:0] a, input logic [52:0] b, input int hold,
                          input int pulse_at, input bit ack_start);
        int           lat [3];
        logic [127:0] exp_p [3];
        int           e;
        bit           done;
        for (int i = 0; i < 3; i++) begin
            lat[i]   = -1;
            exp_p[i] = ref_prod(i, a, b);
        end
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        e    = 0;
        done = 1'b0;
        while (!done && e < 100) begin
            @(posedge clk);
            e++;
            #1;
            for (int i = 0; i < 3; i++) begin
                if (lat[i] < 0 && vld[i]) lat[i] = e;
            end
            if (e == pulse_at) begin
                start = 1'b1;
                a_in  = ~a;
                b_in  = b ^ 53'h5a5a5;
            end else if (e == pulse_at + 1) begin
                start = 1'b0;
            end
            done = (lat[0] >= 0) && (lat[1] >= 0) && (lat[2] >= 0);
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("latency[%0d]", i), 128'(lat[i]), 128'(ref_lat(i, b)));
            chk($sformatf("product[%0d]", i), prd[i], exp_p[i]);
            chk($sformatf("zero[%0d]", i), 128'(zro[i]), 128'(exp_p[i] == '0));
        end
        repeat (hold) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("hold_valid[%0d]", i), 128'(vld[i]), 128'(1));
                chk($sformatf("hold_product[%0d]", i), prd[i], exp_p[i]);
            end
        end
        ack = 1'b1;
        if (ack_start) begin
            start = 1'b1;
            a_in  = ~a;
            b_in  = ~b;
        end
        @(posedge clk);
        #1;
        ack   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ack_valid_low[%0d]", i), 128'(vld[i]), 128'(0));
            chk($sformatf("ack_busy_low[%0d]", i), 128'(bsy[i]), 128'(0));
            chk($sformatf("after_ack_product[%0d]", i), prd[i], exp_p[i]);
        end
        if (ack_start) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("start_with_ack_ignored[%0d]", i), 128'(bsy[i]), 128'(0));
            end
        end
    endtask

    typedef struct {
        logic [23:0] a;
        logic [23:0] b;
        logic [47:0] p;
        logic        z;
    } vec_t;

    vec_t vt [8];

    initial begin
        logic [52:0] ra, rb, m;
        logic [63:0] t;
        bit          seen;

        vt[0] = '{24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 1'b0};
        vt[1] = '{24'h800000, 24'hC00000, 48'h600000000000, 1'b0};
        vt[2] = '{24'h123456, 24'h000000, 48'h000000000000, 1'b1};
        vt[3] = '{24'h000000, 24'hFFFFFF, 48'h000000000000, 1'b1};
        vt[4] = '{24'h000001, 24'h000001, 48'h000000000001, 1'b0};
        vt[5] = '{24'h000002, 24'h800000, 48'h000001000000, 1'b0};
        vt[6] = '{24'h00FFFF, 24'h000100, 48'h000000FFFF00, 1'b0};
        vt[7] = '{24'h000003, 24'h400001, 48'h000000C00003, 1'b0};

        arst_n = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        ack    = 1'b0;
        a_in   = '0;
        b_in   = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_busy[%0d]", i), 128'(bsy[i]), 128'(0));
            chk($sformatf("reset_valid[%0d]", i), 128'(vld[i]), 128'(0));
            chk($sformatf("reset_product[%0d]", i), prd[i], 128'(0));
            chk($sformatf("reset_zero[%0d]", i), 128'(zro[i]), 128'(0));
        end
        @(negedge clk);
        arst_n = 1'b1;

        // Table vectors, the first one held unacknowledged for five cycles.
        for (int k = 0; k < 8; k++) begin
            run_op(53'(vt[k].a), 53'(vt[k].b), (k == 0) ? 5 : 0, -1, 1'b0);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("table%0d_product[%0d]", k, i), prd[i], 128'(vt[k].p));
                chk($sformatf("table%0d_zero[%0d]", k, i), 128'(zro[i]), 128'(vt[k].z));
            end
        end

        // start pulsed mid-run with other operands must not disturb the result.
        run_op(53'h123457, 53'hABCDEF, 0, 3, 1'b0);

        // start together with ack: ack honoured, start dropped.
        run_op(53'h0F0F0F, 53'h00F001, 0, -1, 1'b1);

        // Abort during the third cycle of iteration.
        @(negedge clk);
        a_in  = 53'hFFFFFF;
        b_in  = 53'hFFFFFF;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("abort_busy[%0d]", i), 128'(bsy[i]), 128'(0));
            chk($sformatf("abort_valid[%0d]", i), 128'(vld[i]), 128'(0));
            chk($sformatf("abort_product_kept[%0d]", i), prd[i], ref_prod(i, 53'h0F0F0F, 53'h00F001));
        end
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) if (vld[i] || bsy[i]) seen = 1'b1;
        end
        chk("abort_never_valid", 128'(seen), 128'(0));

        // abort and start together in idle: nothing captured.
        @(negedge clk);
        a_in  = 53'h111111;
        b_in  = 53'h222222;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("idle_abort_start_busy[%0d]", i), 128'(bsy[i]), 128'(0));
        end

        // Asynchronous reset in the middle of iteration.
        @(negedge clk);
        a_in  = 53'h7654321;
        b_in  = 53'h0ABCDE1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 arst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("arst_busy[%0d]", i), 128'(bsy[i]), 128'(0));
            chk($sformatf("arst_valid[%0d]", i), 128'(vld[i]), 128'(0));
            chk($sformatf("arst_product[%0d]", i), prd[i], 128'(0));
            chk($sformatf("arst_zero[%0d]", i), 128'(zro[i]), 128'(0));
        end
        @(negedge clk);
        arst_n = 1'b1;
        run_op(53'h1ABCDEF, 53'h0FEDCBA, 0, -1, 1'b0);

        // Random operands, some with cleared low bits to create trailing zero chunks.
        for (int r = 0; r < 500; r++) begin
            t  = {$urandom(), $urandom()};
            ra = t[52:0];
            t  = {$urandom(), $urandom()};
            rb = t[52:0];
            case ($urandom_range(0, 7))
                0: rb = '0;
                1, 2: begin
                    m  = '1;
                    m  = m << $urandom_range(0, 52);
                    rb = rb & m;
                end
                3: ra = '1;
                default: begin
                end
            endcase
            run_op(ra, rb, 0, -1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
